// File: rtl/full_mat_pkg.sv
// Shared types and widths for the full-matrix sequencer.
package full_mat_pkg;

  localparam int unsigned COUNT_W  = 8;
  localparam int unsigned DH_W     = 21;
  localparam int unsigned N_JOINTS = 6;
  localparam int unsigned N_DH     = 4;

  typedef logic [N_JOINTS-1:0][N_DH-1:0][DH_W-1:0] dh_param_t;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/full_mat_seq.sv
// Sequences one full_mat run (clear, count, multiplier drain, done) and arbitrates
// the shared multipliers with an external requester between runs.
module full_mat_seq
  import full_mat_pkg::*;
#(
  parameter logic [COUNT_W-1:0] COUNT_LAST = 8'd47,
  parameter int unsigned        MULT_LAT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  dh_param_t          dh_param_in,
  input  logic               ext_req,
  output dh_param_t          dh_param,
  output logic               fm_rst,
  output logic               fm_en,
  output logic [COUNT_W-1:0] fm_count,
  output logic               mult_owner,
  output logic               ext_gnt,
  output logic               busy,
  output logic               done
);

  localparam int unsigned DRAIN_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  state_e             state_q;
  logic               start_pend_q;
  logic [DRAIN_W-1:0] drain_cnt_q;

  // Busy covers a queued request as well as any state that owns the multipliers.
  assign busy = start_pend_q | (state_q == CLEAR) | (state_q == RUN) |
                (state_q == DRAIN) | (state_q == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      start_pend_q <= 1'b0;
      drain_cnt_q  <= '0;
      dh_param     <= '0;
      fm_rst       <= 1'b0;
      fm_en        <= 1'b0;
      fm_count     <= '0;
      mult_owner   <= 1'b0;
      ext_gnt      <= 1'b0;
      done         <= 1'b0;
    end else begin
      fm_rst <= 1'b0;
      done   <= 1'b0;
      case (state_q)
        IDLE: begin
          // A new or queued start wins over the external requester.
          if (start || start_pend_q) begin
            state_q      <= CLEAR;
            dh_param     <= dh_param_in;
            start_pend_q <= 1'b0;
            fm_rst       <= 1'b1;
            fm_en        <= 1'b0;
            fm_count     <= '0;
          end else if (ext_req) begin
            state_q    <= EXT;
            ext_gnt    <= 1'b1;
            mult_owner <= 1'b1;
          end
        end
        EXT: begin
          if (start) start_pend_q <= 1'b1;
          if (!ext_req) begin
            state_q    <= IDLE;
            ext_gnt    <= 1'b0;
            mult_owner <= 1'b0;
          end
        end
        CLEAR, RUN, DRAIN: begin
          if (abort) begin
            state_q      <= IDLE;
            start_pend_q <= 1'b0;
            fm_en        <= 1'b0;
            fm_count     <= '0;
          end else begin
            if (start) start_pend_q <= 1'b1;
            if (state_q == CLEAR) begin
              state_q  <= RUN;
              fm_en    <= 1'b1;
              fm_count <= '0;
            end else if (state_q == RUN) begin
              if (fm_count == COUNT_LAST) begin
                state_q     <= DRAIN;
                fm_en       <= 1'b0;
                drain_cnt_q <= '0;
              end else begin
                fm_count <= fm_count + COUNT_W'(1);
              end
            end else begin
              // Let the multiplier pipeline empty before reporting completion.
              if (drain_cnt_q == DRAIN_W'(MULT_LAT - 1)) begin
                state_q <= DONE;
                done    <= 1'b1;
              end else begin
                drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
              end
            end
          end
        end
        DONE: begin
          if (start) start_pend_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/full_mat_seq.md
FULL_MAT_SEQ -- requirements
Module: full_mat_seq

Interface
REQ-001 SHALL have parameter COUNT_LAST, default 8'd47: final fm_count value of a run (48 run cycles).
REQ-002 SHALL have parameter MULT_LAT, default 4: shared-multiplier pipeline depth, drained before done.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  request one full-matrix run; single-cycle pulse or level.
REQ-006 abort  in  1  cancel run in progress.
REQ-007 dh_param_in  in  6x4x21  DH parameters for the run.
REQ-008 ext_req  in  1  second requester (Jacobian stage) asks for the shared multipliers.
REQ-009 dh_param  out  6x4x21  DH parameters latched at start acceptance; drives full_mat.
REQ-010 fm_rst  out  1  one-cycle clear to full_mat.
REQ-011 fm_en  out  1  enable to full_mat.
REQ-012 fm_count  out  8  step index to full_mat.
REQ-013 mult_owner  out  1  shared-multiplier mux select: 0 = full_mat, 1 = external.
REQ-014 ext_gnt  out  1  grant to external requester.
REQ-015 busy  out  1  run pending or active.
REQ-016 done  out  1  one-cycle run-complete pulse.

Function
REQ-017 FSM states SHALL be IDLE, EXT, CLEAR, RUN, DRAIN, DONE.
REQ-018 IDLE: start or start_pend -> CLEAR (latch dh_param_in into dh_param); else ext_req -> EXT; start beats ext_req on the same edge.
REQ-019 CLEAR: fm_rst=1, fm_en=0, fm_count=0; -> RUN next edge.
REQ-020 RUN: fm_en=1, fm_count counts 0..COUNT_LAST, +1 per cycle; at COUNT_LAST -> DRAIN; no wrap past COUNT_LAST.
REQ-021 DRAIN: fm_en=0, fm_count held at COUNT_LAST, MULT_LAT cycles, then -> DONE.
REQ-022 DONE: done=1 for exactly one cycle; -> IDLE; dh_param held until next accepted start.
REQ-023 Latency: with defaults, done high in the cycle after the 53rd edge following the start-sampling edge (2+COUNT_LAST+MULT_LAT).
REQ-024 EXT: ext_gnt=1, mult_owner=1; stays while ext_req=1; ext_req=0 -> IDLE; ext_gnt and mult_owner low the cycle after.
REQ-025 mult_owner SHALL be 0 in CLEAR, RUN, DRAIN, DONE; ext_gnt and fm_en never both 1.
REQ-026 start sampled in EXT, CLEAR, RUN, DRAIN or DONE SHALL set start_pend (one deep, extras dropped); start_pend clears on entering CLEAR.
REQ-027 abort in CLEAR, RUN or DRAIN -> IDLE next edge; fm_en=0, fm_count=0, no done; start_pend cleared; abort ignored in IDLE, EXT, DONE.
REQ-028 busy = start_pend OR state in {CLEAR, RUN, DRAIN, DONE}.

Reset
REQ-029 rst low SHALL force IDLE, start_pend=0, dh_param=0, fm_rst=0, fm_en=0, fm_count=0, mult_owner=0, ext_gnt=0, busy=0, done=0 immediately; first transition on first clk edge after rst high.
REQ-030 Reset mid-run SHALL discard the run with no done pulse.

Structure
REQ-031 full_mat_pkg SHALL hold the state enum, COUNT_W=8, DH_W=21, and the 6x4x21 DH param packed type.
REQ-032 Single module, no sub-modules; all outputs registered except busy.

Verification
REQ-033 Reset then start pulse, defaults -> fm_rst one cycle, fm_count 0..47 with fm_en over 48 cycles, 4 drain cycles, done one cycle at edge 53, dh_param equals sampled dh_param_in.
REQ-034 start and ext_req same cycle in IDLE -> run proceeds, ext_gnt stays 0 until after DONE, then ext_gnt=1.
REQ-035 ext_req held 10 cycles, start at cycle 3 -> start_pend/busy=1, CLEAR entered one edge after ext_req falls, mult_owner 0 before fm_en.
REQ-036 abort at fm_count=20 -> IDLE next edge, fm_en=0, fm_count=0, no done; new start completes normally.
REQ-037 rst low at fm_count=30 -> all outputs 0 asynchronously, no done after release.
REQ-038 Two start pulses during RUN -> exactly two runs complete, two done pulses.
